cla_sub_pipe: RTL and testbench

- Pipelined 16-bit borrow-lookahead subtractor computing D = A - B - Bin.
- Inverse companion to the team's 16-bit carry-lookahead adder.
- Computes one 4-bit group per stage, each stage with full lookahead.
- Valid/ready handshake on both sides. Exports group borrow-propagate/generate and status flags for the ALU compare/branch path.

---
 rtl/cla_sub_pipe.sv | 166 ++++++++++++++++
 tb/tb_cla_sub_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: pipelined borrow-lookahead subtractor, D = A - B - Bin.
// Each register stage resolves one GROUP-bit slice with flat lookahead from
// the borrow registered by the previous stage. Operands ride along in skew
// registers; resolved difference bits accumulate toward the output stage.
// The whole pipe advances together whenever the output register is empty
// or being drained, so in_ready is a pure function of the output side.
module cla_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             PG,
  output logic             GG,
  output logic             V,
  output logic             Z
);

  localparam int NS = WIDTH / GROUP;

  // Result of resolving one slice: difference bits, borrow out of the slice,
  // and the slice's borrow-propagate / borrow-generate (borrow-in excluded).
  typedef struct packed {
    logic [GROUP-1:0] d;
    logic             bout;
    logic             pg;
    logic             gg;
  } grp_t;

  // Flat lookahead for one slice: every internal borrow is a sum of
  // products of g, p and the incoming borrow, with no ripple through bits.
  function automatic grp_t grp_sub(input logic [GROUP-1:0] a,
                                   input logic [GROUP-1:0] b,
                                   input logic             bin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   bw;
    logic             t;
    grp_t             r;
    g = ~a & b;
    p = ~(a ^ b);
    for (int i = 0; i <= GROUP; i++) begin
      bw[i] = bin;
      for (int j = 0; j < i; j++) bw[i] = bw[i] & p[j];
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        bw[i] = bw[i] | t;
      end
    end
    r.gg = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      t = g[j];
      for (int k = j + 1; k < GROUP; k++) t = t & p[k];
      r.gg = r.gg | t;
    end
    r.pg   = &p;
    r.bout = bw[GROUP];
    r.d    = a ^ b ^ bw[GROUP-1:0];
    return r;
  endfunction

  // Signed overflow of a subtraction: operands differ in sign and the
  // result sign differs from the minuend.
  function automatic logic sub_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

  // Control
  logic [NS-1:0] vld_p;
  logic          advance;

  // Intermediate stages 0..NS-2 (the last stage drives the ports directly)
  logic [WIDTH-1:0] a_p  [NS-1];
  logic [WIDTH-1:0] b_p  [NS-1];
  logic [WIDTH-1:0] d_p  [NS-1];
  logic [NS-2:0]    br_p;
  logic [NS-2:0]    pg_p;
  logic [NS-2:0]    gg_p;

  // Combinational slice results feeding each register stage
  grp_t             grp_c [NS];
  logic [WIDTH-1:0] dn    [NS];

  assign advance   = ~vld_p[NS-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p[NS-1];

  // Slice k is resolved from the operands held in stage k-1 (or the ports
  // for k=0) and merged into the accumulated low difference bits.
  always_comb begin
    grp_c[0] = grp_sub(A[GROUP-1:0], B[GROUP-1:0], Bin);
    dn[0]    = '0;
    dn[0][GROUP-1:0] = grp_c[0].d;
    for (int k = 1; k < NS; k++) begin
      grp_c[k] = grp_sub(a_p[k-1][k*GROUP +: GROUP],
                         b_p[k-1][k*GROUP +: GROUP],
                         br_p[k-1]);
      dn[k] = d_p[k-1];
      dn[k][k*GROUP +: GROUP] = grp_c[k].d;
    end
  end

  // Valid bits shift with the data; bubbles travel as valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p <= {vld_p[NS-2:0], in_valid};
    end
  end

  // ---- stage boundary: inputs -> p0 ; p(k-1) -> pk for k = 1..NS-2 ----
  always_ff @(posedge clk) begin
    if (advance) begin
      a_p[0]  <= A;
      b_p[0]  <= B;
      d_p[0]  <= dn[0];
      br_p[0] <= grp_c[0].bout;
      pg_p[0] <= grp_c[0].pg;
      gg_p[0] <= grp_c[0].gg;
      for (int k = 1; k < NS - 1; k++) begin
        a_p[k]  <= a_p[k-1];
        b_p[k]  <= b_p[k-1];
        d_p[k]  <= dn[k];
        br_p[k] <= grp_c[k].bout;
        pg_p[k] <= pg_p[k-1] & grp_c[k].pg;
        gg_p[k] <= grp_c[k].gg | (grp_c[k].pg & gg_p[k-1]);
      end
    end
  end

  // ---- stage boundary: p(NS-2) -> output registers ----
  // Output registers resolve the top slice and the status flags; they are
  // cleared by reset and frozen while a result waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      D    <= '0;
      Bout <= 1'b0;
      PG   <= 1'b0;
      GG   <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b0;
    end else if (advance) begin
      D    <= dn[NS-1];
      Bout <= grp_c[NS-1].bout;
      PG   <= pg_p[NS-2] & grp_c[NS-1].pg;
      GG   <= grp_c[NS-1].gg | (grp_c[NS-1].pg & gg_p[NS-2]);
      V    <= sub_ovf(a_p[NS-2][WIDTH-1], b_p[NS-2][WIDTH-1],
                      dn[NS-1][WIDTH-1]);
      Z    <= (dn[NS-1] == '0);
    end
  end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// tb_cla_sub_pipe: directed self-checking bench for cla_sub_pipe.
module tb_cla_sub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         PG;
  logic         GG;
  logic         V;
  logic         Z;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_sub_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .PG        (PG),
    .GG        (GG),
    .V         (V),
    .Z         (Z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: 17-bit unsigned subtraction, bit 16 is the borrow out.
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
    return {1'b0, a} - {1'b0, b} - 17'(bin);
  endfunction

  // One isolated operation: checks latency and every output field.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic [15:0] ed, input logic ebout,
                        input logic epg, input logic egg, input logic ev, input logic ez);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = a;
    B = b;
    Bin = bin;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_D"}, D, ed);
    chk({tag, "_Bout"}, Bout, ebout);
    chk({tag, "_PG"}, PG, epg);
    chk({tag, "_GG"}, GG, egg);
    chk({tag, "_V"}, V, ev);
    chk({tag, "_Z"}, Z, ez);
    @(posedge clk); #1;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic        sbin [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int idx;
    int rcv;
    int c;
    int stale;
    logic [16:0] exp;

    sa = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'hABCD, 16'h0F0F, 16'h5555};
    sb = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'hABCD, 16'hF0F0, 16'hAAAA};
    sbin = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_D", D, 0);
    chk("reset_flags", {Bout, PG, GG, V, Z}, 0);

    //     tag        A         B         Bin   D         Bout  PG    GG    V     Z
    run_op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("wrap",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("prop_b1", 16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("prop_b0", 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("bin_only",16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with out_ready low in cycles 5..8.
    idx = 0;
    rcv = 0;
    c = 0;
    while (rcv < 8 && c < 60) begin
      c++;
      out_ready = !(c >= 5 && c <= 8);
      in_valid = (idx < 8);
      if (idx < 8) begin
        A = sa[idx];
        B = sb[idx];
        Bin = sbin[idx];
      end
      #1;
      chk("stream_in_ready", in_ready, !(c >= 5 && c <= 8));
      if (c >= 5 && c <= 8) chk("stream_hold_valid", out_valid, 1);
      if (out_valid) begin
        exp = ref_sub(sa[rcv], sb[rcv], sbin[rcv]);
        chk(out_ready ? "stream_out" : "stream_hold", {15'd0, Bout, D}, {15'd0, exp});
        chk("stream_Z", Z, D == 16'h0000 ? 1 : 0);
        if (out_ready) rcv++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", rcv, 8);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      A = sa[i];
      B = sb[i];
      Bin = sbin[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_D", D, 0);
    chk("midrst_in_ready", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("midrst_no_stale", stale, 0);
    run_op("post_rst", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
